rr_credit_dispatcher: RTL and testbench

Round-robin 1-to-N dispatcher: the distributing counterpart of the round-robin request arbiter.
- Accepts one valid/ready input stream and forwards each beat to exactly one of CH_NUM downstream consumers.
- A channel is chosen by round-robin among channels that are enabled and hold at least one credit.
- Consumers return credits as buffer slots free up, so downstream never overflows.
- Sits in front of replicated processing lanes.

---
 rtl/rr_credit_dispatcher.sv | 114 +++++++++++
 tb/tb_rr_credit_dispatcher.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_credit_dispatcher.sv
// Round-robin 1-to-N dispatcher: forwards each input beat to one enabled channel
// holding a credit, with per-channel credit counters fed by downstream returns.
module rr_credit_lane #(
    parameter int CREDIT_MAX = 4,
    parameter int CRED_W     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_take,
    input  logic              i_ret,
    output logic [CRED_W-1:0] o_cnt,
    output logic              o_ovf
);
    localparam logic [CRED_W-1:0] FULL = CRED_W'(CREDIT_MAX);

    logic [CRED_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= FULL;
        end else begin
            case ({i_take, i_ret})
                2'b10:   r_cnt <= r_cnt - CRED_W'(1);
                2'b01:   if (r_cnt != FULL) r_cnt <= r_cnt + CRED_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_cnt = r_cnt;
    // A lone return into a full counter is dropped and flagged.
    assign o_ovf = i_ret & ~i_take & (r_cnt == FULL);
endmodule

module rr_credit_dispatcher #(
    parameter  int CH_NUM     = 4,
    parameter  int DATA_W     = 32,
    parameter  int CREDIT_MAX = 4,
    localparam int CRED_W     = $clog2(CREDIT_MAX + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [CH_NUM-1:0]        ch_en,
    output logic [CH_NUM-1:0]        out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic [CH_NUM-1:0]        credit_ret,
    output logic [CH_NUM*CRED_W-1:0] credit_cnt,
    output logic                     err_ovf
);
    logic [CH_NUM-1:0]             w_elig;
    logic [CH_NUM-1:0]             w_masked;
    logic [CH_NUM-1:0]             w_req;
    logic [CH_NUM-1:0]             w_grant;
    logic [CH_NUM-1:0]             w_take;
    logic [CH_NUM-1:0]             w_ovf;
    logic [CH_NUM-1:0][CRED_W-1:0] w_cnt;
    logic                          w_fire;

    logic [CH_NUM-1:0] r_mask;
    logic [CH_NUM-1:0] r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_err;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_lane
        rr_credit_lane #(
            .CREDIT_MAX (CREDIT_MAX),
            .CRED_W     (CRED_W)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_take (w_take[g]),
            .i_ret  (credit_ret[g]),
            .o_cnt  (w_cnt[g]),
            .o_ovf  (w_ovf[g])
        );
        assign w_elig[g] = ch_en[g] & (w_cnt[g] != '0);
        assign credit_cnt[g*CRED_W +: CRED_W] = w_cnt[g];
    end

    // Masked request wins if any; otherwise wrap to the unmasked set. Lowest set bit is the grant.
    always_comb begin
        w_masked = w_elig & r_mask;
        w_req    = (|w_masked) ? w_masked : w_elig;
        w_grant  = w_req & (~w_req + CH_NUM'(1));
        w_fire   = in_valid & (|w_elig);
        w_take   = w_fire ? w_grant : '0;
    end

    assign in_ready = |w_elig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask      <= '1;
            r_out_valid <= '0;
            r_out_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= w_take;
            r_err       <= r_err | (|w_ovf);
            if (w_fire) begin
                // Keep only channels above the winner so it becomes lowest priority.
                r_mask     <= ~(w_grant | (w_grant - CH_NUM'(1)));
                r_out_data <= in_data;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign err_ovf   = r_err;
endmodule

// File: tb/tb_rr_credit_dispatcher.sv
// Randomized + directed bench for rr_credit_dispatcher against a pointer-based round-robin model.
module tb_rr_credit_dispatcher;
    localparam int CH  = 4;
    localparam int DW  = 32;
    localparam int MAX = 4;
    localparam int CW  = $clog2(MAX + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic [CH-1:0]     ch_en;
    logic [CH-1:0]     out_valid;
    logic [DW-1:0]     out_data;
    logic [CH-1:0]     credit_ret;
    logic [CH*CW-1:0]  credit_cnt;
    logic              err_ovf;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // reference model state
    int            m_cnt [CH];
    int            m_ptr;
    bit            m_err;
    logic [CH-1:0] m_ov;
    logic [DW-1:0] m_od;

    rr_credit_dispatcher #(.CH_NUM(CH), .DATA_W(DW), .CREDIT_MAX(MAX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .ch_en      (ch_en),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .credit_ret (credit_ret),
        .credit_cnt (credit_cnt),
        .err_ovf    (err_ovf)
    );

    always #5 clk = ~clk;

    function automatic bit m_elig(int k);
        return ch_en[k] && (m_cnt[k] > 0);
    endfunction

    function automatic bit m_ready();
        for (int k = 0; k < CH; k++) if (m_elig(k)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_winner();
        for (int i = 0; i < CH; i++) begin
            int c = (m_ptr + i) % CH;
            if (m_elig(c)) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < CH; k++) m_cnt[k] = MAX;
        m_ptr = 0; m_err = 1'b0; m_ov = '0; m_od = '0;
    endtask

    task automatic model_step();
        bit fire;
        int w;
        fire = in_valid && m_ready();
        w    = fire ? m_winner() : -1;
        m_ov = '0;
        if (fire) begin
            m_ov[w] = 1'b1;
            m_od    = in_data;
            m_ptr   = (w + 1) % CH;
        end
        for (int k = 0; k < CH; k++) begin
            bit take = (w == k);
            if (credit_ret[k] && !take) begin
                if (m_cnt[k] == MAX) m_err = 1'b1;
                else m_cnt[k]++;
            end else if (take && !credit_ret[k]) begin
                m_cnt[k]--;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] cnt_of(int k);
        return credit_cnt[k*CW +: CW];
    endfunction

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_ready", 64'(in_ready), 64'(m_ready()));
            chk("out_valid", 64'(out_valid), 64'(m_ov));
            chk("out_data", 64'(out_data), 64'(m_od));
            chk("err_ovf", 64'(err_ovf), 64'(m_err));
            for (int k = 0; k < CH; k++) chk("credit_cnt", 64'(cnt_of(k)), 64'(m_cnt[k]));
        end
    end

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; credit_ret = '0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic chk_all_cnt(input string name, input int v);
        for (int k = 0; k < CH; k++) chk(name, 64'(cnt_of(k)), 64'(v));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; ch_en = 4'b1111; credit_ret = '0;
        model_reset();
        #12;
        chk_on = 1'b1;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_err", 64'(err_ovf), 64'h0);
        chk_all_cnt("rst_cnt", MAX);
        do_reset();

        // 1: four fires rotate 0..3, strobe one cycle later
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hA0 + 32'(i);
            step();
            chk("t1_ov", 64'(out_valid), 64'(4'b0001 << i));
            chk("t1_od", 64'(out_data), 64'(32'hA0 + i));
        end
        in_valid = 1'b0;
        step();
        chk("t1_ov_idle", 64'(out_valid), 64'h0);
        chk_all_cnt("t1_cnt", 3);

        // 2: drain remaining credits, then one return on channel 2
        in_valid = 1'b1;
        for (int i = 4; i < 16; i++) begin
            in_data = 32'hB0 + 32'(i);
            step();
            chk("t2_ov", 64'(out_valid), 64'(4'b0001 << (i % 4)));
        end
        chk("t2_stall", 64'(in_ready), 64'h0);
        chk_all_cnt("t2_cnt0", 0);
        credit_ret = 4'b0100;
        step();
        credit_ret = '0;
        chk("t2_ready", 64'(in_ready), 64'h1);
        chk("t2_noov", 64'(out_valid), 64'h0);
        in_data = 32'hC2;
        step();
        chk("t2_ch2", 64'(out_valid), 64'b0100);
        chk("t2_od", 64'(out_data), 64'hC2);
        in_valid = 1'b0;

        // 3: only odd channels enabled
        do_reset();
        ch_en = 4'b1010; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'(i);
            step();
            chk("t3_ov", 64'(out_valid), (i % 2) ? 64'b1000 : 64'b0010);
        end
        in_valid = 1'b0;
        step();
        chk("t3_cnt0", 64'(cnt_of(0)), 64'd4);
        chk("t3_cnt2", 64'(cnt_of(2)), 64'd4);
        chk("t3_cnt1", 64'(cnt_of(1)), 64'd2);

        // 4: dispatch + return cancel; return into full counter flags overflow
        ch_en = 4'b0010; in_valid = 1'b1;
        step();
        chk("t4_cnt1a", 64'(cnt_of(1)), 64'd1);
        credit_ret = 4'b0010;
        step();
        chk("t4_ov", 64'(out_valid), 64'b0010);
        chk("t4_cnt1b", 64'(cnt_of(1)), 64'd1);
        chk("t4_noerr", 64'(err_ovf), 64'h0);
        in_valid = 1'b0; credit_ret = 4'b0001;
        step();
        credit_ret = '0;
        chk("t4_cnt0", 64'(cnt_of(0)), 64'd4);
        chk("t4_err", 64'(err_ovf), 64'h1);
        step(); step();
        chk("t4_sticky", 64'(err_ovf), 64'h1);

        // 5: idle cycle between grants does not advance priority
        do_reset();
        ch_en = 4'b1111; in_valid = 1'b1;
        step(); step();
        step();
        chk("t5_g2", 64'(out_valid), 64'b0100);
        in_valid = 1'b0;
        step();
        chk("t5_idle", 64'(out_valid), 64'h0);
        in_valid = 1'b1;
        step();
        chk("t5_g3", 64'(out_valid), 64'b1000);

        // 6: reset right after a strobe drops it immediately
        do_reset();
        in_valid = 1'b1;
        step(); step();
        chk("t6_pre", 64'(out_valid), 64'b0010);
        in_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_ov0", 64'(out_valid), 64'h0);
        chk_all_cnt("t6_cnt", MAX);
        @(negedge clk);
        #2 rst_n = 1'b1;
        in_valid = 1'b1;
        step();
        chk("t6_ch0", 64'(out_valid), 64'b0001);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_data    = $urandom;
            ch_en      = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b1111;
            credit_ret = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end
        in_valid = 1'b0; credit_ret = '0;
        step();
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
